// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel between I and D refills.
// D has priority; I wins after STARVE_LIMIT consecutive D grants.
module axi_rd_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [3:0]  I_ID         = 4'd0,
  parameter logic [3:0]  D_ID         = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  input  logic        wr_busy,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [2:0]  starve_q, starve_d;
  logic [7:0]  beat_q, beat_d;
  logic        proto_err_q, proto_err_d;
  logic        id_err_q, id_err_d;

  logic d_req, i_req;
  logic pick_d, pick_i;
  logic in_idle, in_data;
  logic fire;

  // Qualify requests and pick the winner; D loses only to a starved I
  always_comb begin
    d_req  = d_arvalid & ~wr_busy;
    i_req  = i_arvalid;
    pick_d = d_req & ~(i_req & (starve_q == LIMIT));
    pick_i = i_req & ~pick_d;
  end

  assign in_idle = (state_q == IDLE);
  assign in_data = (state_q == DATA);

  assign i_arready = aresetn & in_idle & pick_i;
  assign d_arready = aresetn & in_idle & pick_d;

  assign rready = in_data & (owner_q ? d_rready : i_rready);
  assign fire   = rvalid & rready;

  assign i_rvalid = in_data & ~owner_q & rvalid;
  assign i_rlast  = in_data & ~owner_q & rlast;
  assign i_rdata  = (in_data & ~owner_q) ? rdata : '0;
  assign d_rvalid = in_data & owner_q & rvalid;
  assign d_rlast  = in_data & owner_q & rlast;
  assign d_rdata  = (in_data & owner_q) ? rdata : '0;

  assign arvalid = (state_q == ADDR);
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;

  // Next-state: grant capture, AR handshake, beat tracking
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    arid_d      = arid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    starve_d    = starve_q;
    beat_d      = beat_q;
    proto_err_d = proto_err_q;
    id_err_d    = id_err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d | pick_i) begin
          state_d  = ADDR;
          owner_d  = pick_d;
          arid_d   = pick_d ? D_ID : I_ID;
          araddr_d = pick_d ? d_araddr : i_araddr;
          arlen_d  = pick_d ? d_arlen : i_arlen;
          arsize_d = pick_d ? d_arsize : i_arsize;
          if (pick_d & i_arvalid) begin
            if (starve_q != LIMIT) begin
              starve_d = starve_q + 3'd1;
            end
          end else begin
            starve_d = '0;
          end
        end
      end
      ADDR: begin
        if (arready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (fire) begin
          beat_d = beat_q + 8'd1;
          // rid is not used for routing; a mismatch is only recorded
          if (rid != arid_q) begin
            id_err_d = 1'b1;
          end
          if (rlast) begin
            state_d = IDLE;
            if (beat_q != arlen_q) begin
              proto_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fire & ~in_data) begin
      proto_err_d = 1'b1;
    end
  end

  // State and AR register bank
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      arid_q      <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      starve_q    <= '0;
      beat_q      <= '0;
      proto_err_q <= 1'b0;
      id_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      arid_q      <= arid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      starve_q    <= starve_d;
      beat_q      <= beat_d;
      proto_err_q <= proto_err_d;
      id_err_q    <= id_err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed scoreboard bench for axi_rd_arbiter.
// AR and R expectations are queued at stimulus time, popped on output.
module tb_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] i_araddr, d_araddr;
  logic [7:0]  i_arlen, d_arlen;
  logic [2:0]  i_arsize, d_arsize;
  logic        i_arvalid, d_arvalid;
  logic        i_arready, d_arready;
  logic [31:0] i_rdata, d_rdata;
  logic        i_rlast, d_rlast;
  logic        i_rvalid, d_rvalid;
  logic        i_rready, d_rready;
  logic        wr_busy;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi_rd_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata),
    .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen),
    .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata),
    .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_rready(d_rready),
    .wr_busy(wr_busy),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  ar_t         ar_q[$];
  logic [31:0] r_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          i_gr, d_gr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock; a granted request is withdrawn after the edge
  task automatic step();
    #2;
    i_gr = i_arready;
    d_gr = d_arready;
    @(posedge aclk);
    #1;
    if (i_gr) i_arvalid = 1'b0;
    if (d_gr) d_arvalid = 1'b0;
  endtask

  task automatic drive_i(input logic [31:0] a,
                         input logic [7:0] l);
    i_araddr  = a;
    i_arlen   = l;
    i_arsize  = 3'd2;
    i_arvalid = 1'b1;
  endtask

  task automatic drive_d(input logic [31:0] a,
                         input logic [7:0] l);
    d_araddr  = a;
    d_arlen   = l;
    d_arsize  = 3'd2;
    d_arvalid = 1'b1;
  endtask

  task automatic exp_ar(input logic [3:0] id,
                        input logic [31:0] a,
                        input logic [7:0] l);
    ar_q.push_back('{id, a, l, 3'd2});
  endtask

  task automatic ar_phase(input string tag);
    ar_t e;
    int  k;
    k = 0;
    while (!arvalid && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_arvalid"}, 32'(arvalid), 1);
    chk({tag, "_ar_q"}, 32'(ar_q.size() != 0), 1);
    if (ar_q.size() != 0) begin
      e = ar_q.pop_front();
      chk({tag, "_arid"}, 32'(arid), 32'(e.id));
      chk({tag, "_araddr"}, araddr, e.addr);
      chk({tag, "_arlen"}, 32'(arlen), 32'(e.len));
      chk({tag, "_arsize"}, 32'(arsize), 32'(e.size));
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk({tag, "_ar_drop"}, 32'(arvalid), 0);
  endtask

  task automatic r_burst(input string tag, input bit to_d,
                         input int nb, input bit gaps,
                         input bit bp);
    logic [31:0] w;
    logic        ov, ol, nv;
    logic [31:0] od;
    for (int b = 0; b < nb; b++) begin
      w = $urandom;
      r_q.push_back(w);
      rdata  = w;
      rlast  = (b == nb - 1);
      rvalid = 1'b1;
      rid    = to_d ? 4'd1 : 4'd0;
      if (bp && (b % 3 == 1)) begin
        if (to_d) d_rready = 1'b0;
        else      i_rready = 1'b0;
        #1;
        chk({tag, "_bp_rready"}, 32'(rready), 0);
        step();
        if (to_d) d_rready = 1'b1;
        else      i_rready = 1'b1;
      end
      #1;
      ov = to_d ? d_rvalid : i_rvalid;
      ol = to_d ? d_rlast : i_rlast;
      od = to_d ? d_rdata : i_rdata;
      nv = to_d ? i_rvalid : d_rvalid;
      chk({tag, "_rvalid"}, 32'(ov), 1);
      chk({tag, "_rready"}, 32'(rready), 1);
      chk({tag, "_other_rvalid"}, 32'(nv), 0);
      chk({tag, "_rlast"}, 32'(ol), 32'(b == nb - 1));
      chk({tag, "_rdata"}, od, r_q.pop_front());
      step();
      rvalid = 1'b0;
      rlast  = 1'b0;
      if (gaps && (b % 2 == 0) && (b != nb - 1)) begin
        #1;
        chk({tag, "_gap_rvalid"}, 32'(ov & 1'b0 | (to_d ? d_rvalid : i_rvalid)), 0);
        step();
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_arvalid"}, 32'(arvalid), 0);
    chk({tag, "_arid"}, 32'(arid), 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_arlen"}, 32'(arlen), 0);
    chk({tag, "_arsize"}, 32'(arsize), 0);
    chk({tag, "_rready"}, 32'(rready), 0);
    chk({tag, "_i_arready"}, 32'(i_arready), 0);
    chk({tag, "_d_arready"}, 32'(d_arready), 0);
    chk({tag, "_i_rvalid"}, 32'(i_rvalid), 0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 0);
    chk({tag, "_i_rlast"}, 32'(i_rlast), 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    aresetn   = 1'b0;
    i_araddr  = '0; i_arlen = '0; i_arsize = '0;
    d_araddr  = '0; d_arlen = '0; d_arsize = '0;
    i_arvalid = 1'b0; d_arvalid = 1'b0;
    i_rready  = 1'b1; d_rready = 1'b1;
    wr_busy   = 1'b0; arready = 1'b0;
    rid = '0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    chk_reset_outs("reset");
    aresetn = 1'b1;
    step();

    // Simultaneous requests: D wins, I waits
    drive_i(32'h0000_1000, 8'd3);
    drive_d(32'h0000_2000, 8'd1);
    exp_ar(4'd1, 32'h0000_2000, 8'd1);
    exp_ar(4'd0, 32'h0000_1000, 8'd3);
    #1;
    chk("both_d_arready", 32'(d_arready), 1);
    chk("both_i_arready", 32'(i_arready), 0);
    ar_phase("both_d");
    r_burst("both_d_r", 1'b1, 2, 1'b0, 1'b0);
    ar_phase("both_i");
    r_burst("both_i_r", 1'b0, 4, 1'b0, 1'b0);

    // Starvation: four D bursts, then I forced to win
    drive_i(32'h0000_3000, 8'd0);
    for (int k = 0; k < 4; k++) begin
      drive_d(32'h0000_4000 + 32'(k * 64), 8'd0);
      exp_ar(4'd1, 32'h0000_4000 + 32'(k * 64), 8'd0);
      ar_phase("starve_d");
      r_burst("starve_d_r", 1'b1, 1, 1'b0, 1'b0);
    end
    drive_d(32'h0000_5000, 8'd0);
    exp_ar(4'd0, 32'h0000_3000, 8'd0);
    exp_ar(4'd1, 32'h0000_5000, 8'd0);
    ar_phase("starve_i");
    chk("starve_cnt_clr", 32'(dut.starve_q), 0);
    r_burst("starve_i_r", 1'b0, 1, 1'b0, 1'b0);
    ar_phase("starve_d5");
    r_burst("starve_d5_r", 1'b1, 1, 1'b0, 1'b0);

    // wr_busy holds off D; I proceeds
    wr_busy = 1'b1;
    drive_d(32'h0000_6000, 8'd7);
    drive_i(32'h0000_7000, 8'd1);
    exp_ar(4'd0, 32'h0000_7000, 8'd1);
    #1;
    chk("wrb_i_arready", 32'(i_arready), 1);
    chk("wrb_d_arready", 32'(d_arready), 0);
    ar_phase("wrb_i");
    r_burst("wrb_i_r", 1'b0, 2, 1'b0, 1'b0);

    // D alone under wr_busy stays parked until it drops
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wrb_hold_arready", 32'(d_arready), 0);
      step();
      chk("wrb_hold_arvalid", 32'(arvalid), 0);
    end
    wr_busy = 1'b0;
    exp_ar(4'd1, 32'h0000_6000, 8'd7);
    #1;
    chk("wrb_rel_arready", 32'(d_arready), 1);
    step();
    chk("wrb_rel_arvalid", 32'(arvalid), 1);
    chk("wrb_rel_arid", 32'(arid), 1);
    ar_phase("wrb_d");

    // Eight-beat D burst with gaps and backpressure
    r_burst("len7_r", 1'b1, 8, 1'b1, 1'b1);
    chk("len7_proto_err", 32'(dut.proto_err_q), 0);
    chk("len7_idle_rready", 32'(rready), 0);

    // Request pending during rlast is granted the next cycle
    drive_d(32'h0000_9000, 8'd1);
    exp_ar(4'd1, 32'h0000_9000, 8'd1);
    ar_phase("b2b_d");
    drive_i(32'h0000_8000, 8'd7);
    exp_ar(4'd0, 32'h0000_8000, 8'd7);
    #1;
    chk("b2b_busy_arready", 32'(i_arready), 0);
    r_burst("b2b_d_r", 1'b1, 2, 1'b0, 1'b0);
    #1;
    chk("b2b_i_arready", 32'(i_arready), 1);
    chk("b2b_gap_arvalid", 32'(arvalid), 0);
    step();
    chk("b2b_arvalid", 32'(arvalid), 1);
    chk("b2b_arid", 32'(arid), 0);
    ar_phase("b2b_i");

    // Reset during beat 3 of the I burst
    for (int b = 0; b < 2; b++) begin
      rdata  = $urandom;
      r_q.push_back(rdata);
      rid    = 4'd0;
      rvalid = 1'b1;
      #1;
      chk("rst_pre_rdata", i_rdata, r_q.pop_front());
      step();
      rvalid = 1'b0;
    end
    rvalid  = 1'b1;
    rdata   = 32'hDEAD_BEEF;
    drive_d(32'h0000_A000, 8'd0);
    aresetn = 1'b0;
    #1;
    chk_reset_outs("midrst");
    step();
    aresetn = 1'b1;
    rvalid  = 1'b0;
    exp_ar(4'd1, 32'h0000_A000, 8'd0);
    #1;
    chk("post_rst_arready", 32'(d_arready), 1);
    ar_phase("post_rst");
    r_burst("post_rst_r", 1'b1, 1, 1'b0, 1'b0);
    chk("post_rst_proto_err", 32'(dut.proto_err_q), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
